// File: rtl/data_receiver_if.sv
// Byte-stream receive bus: UART RX byte strobe in, assembled word out.
// master drives bytes and clear; slave is the assembler.
interface data_receiver_if #(
  parameter int NUM_BYTES = 5
);
  localparam int CW = $clog2(NUM_BYTES + 1);

  logic [7:0]             byteIn;
  logic                   byteValid;
  logic                   clear;
  logic [8*NUM_BYTES-1:0] dataOut;
  logic                   dataValid;
  logic                   timeoutErr;
  logic                   busy;
  logic [CW-1:0]          byteCount;

  modport master (
    output byteIn, byteValid, clear,
    input  dataOut, dataValid, timeoutErr,
    input  busy, byteCount
  );

  modport slave (
    input  byteIn, byteValid, clear,
    output dataOut, dataValid, timeoutErr,
    output busy, byteCount
  );
endinterface

// File: rtl/data_receiver.sv
// Assembles LSB-first UART bytes into one NUM_BYTES word.
// An inter-byte idle timeout drops partial frames to resync framing.
module data_receiver #(
  parameter int NUM_BYTES      = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  data_receiver_if.slave bus
);
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int DW = 8 * NUM_BYTES;
  localparam int TW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CLAST = CW'(NUM_BYTES - 1);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] RECEIVING = 1'b1;

  logic [0:0]    state;
  logic [DW-1:0] shadow;
  logic [DW-1:0] data_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          dv_q;
  logic          te_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shadow <= '0;
      data_q <= '0;
      cnt    <= '0;
      timer  <= '0;
      dv_q   <= 1'b0;
      te_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      te_q <= 1'b0;
      if (bus.clear) begin
        cnt   <= '0;
        timer <= '0;
        state <= IDLE;
      end else if (bus.byteValid) begin
        timer <= '0;
        // cnt is 0 in IDLE, so this also lands byte 0
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (cnt == CW'(i)) shadow[8*i +: 8] <= bus.byteIn;
        end
        if (state == IDLE) begin
          cnt   <= CW'(1);
          state <= RECEIVING;
        end else if (cnt == CLAST) begin
          data_q <= {bus.byteIn, shadow[DW-9:0]};
          dv_q   <= 1'b1;
          cnt    <= '0;
          state  <= IDLE;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (state == RECEIVING &&
                   TIMEOUT_CYCLES != 0) begin
        if (timer == TLAST) begin
          cnt   <= '0;
          timer <= '0;
          te_q  <= 1'b1;
          state <= IDLE;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

  assign bus.dataOut    = data_q;
  assign bus.dataValid  = dv_q;
  assign bus.timeoutErr = te_q;
  assign bus.busy       = (state == RECEIVING);
  assign bus.byteCount  = cnt;
endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: per-cycle vector table
// plus hand sequences for reset behaviour.
module tb_data_receiver;
  localparam int NB = 5;
  localparam int TC = 8;

  typedef struct {
    bit          bv;
    logic [7:0]  b;
    bit          clr;
    logic [39:0] d;
    bit          dv;
    bit          te;
    bit          bz;
    int          c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  localparam logic [39:0] W1 = 40'h1122334455;
  localparam logic [39:0] W2 = 40'h1234123412;
  localparam logic [39:0] W3 = 40'h0504030201;
  localparam logic [39:0] W4 = 40'h5040302010;

  data_receiver_if #(.NUM_BYTES(NB)) bus ();

  data_receiver #(
    .NUM_BYTES(NB),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [39:0] d,
                         bit dv, bit te, bit bz, int c);
    chk({nm, ".dataOut"}, 64'(bus.dataOut), 64'(d));
    chk({nm, ".dataValid"}, 64'(bus.dataValid), 64'(dv));
    chk({nm, ".timeoutErr"}, 64'(bus.timeoutErr), 64'(te));
    chk({nm, ".busy"}, 64'(bus.busy), 64'(bz));
    chk({nm, ".byteCount"}, 64'(bus.byteCount), 64'(c));
  endtask

  task automatic add(bit bv, logic [7:0] b, bit clr,
                     logic [39:0] d, bit dv, bit te,
                     bit bz, int c);
    vec_t v;
    v.bv = bv; v.b = b; v.clr = clr; v.d = d;
    v.dv = dv; v.te = te; v.bz = bz; v.c = c;
    vq.push_back(v);
  endtask

  task automatic idle(int n, logic [39:0] d, bit bz, int c);
    for (int i = 0; i < n; i++) add(0, 8'h00, 0, d, 0, 0, bz, c);
  endtask

  task automatic step(bit bv, logic [7:0] b, bit clr);
    bus.byteValid = bv;
    bus.byteIn    = b;
    bus.clear     = clr;
    @(posedge clk);
    #1;
    bus.byteValid = 1'b0;
    bus.clear     = 1'b0;
  endtask

  initial begin
    // frame 1 with one idle cycle between bytes
    add(1, 8'h55, 0, 0, 0, 0, 1, 1); idle(1, 0, 1, 1);
    add(1, 8'h44, 0, 0, 0, 0, 1, 2); idle(1, 0, 1, 2);
    add(1, 8'h33, 0, 0, 0, 0, 1, 3); idle(1, 0, 1, 3);
    add(1, 8'h22, 0, 0, 0, 0, 1, 4); idle(1, 0, 1, 4);
    add(1, 8'h11, 0, W1, 1, 0, 0, 0);
    // back-to-back frame starts while dataValid is high
    add(1, 8'h12, 0, W1, 0, 0, 1, 1);
    add(1, 8'h34, 0, W1, 0, 0, 1, 2);
    add(1, 8'h12, 0, W1, 0, 0, 1, 3);
    add(1, 8'h34, 0, W1, 0, 0, 1, 4);
    add(1, 8'h12, 0, W2, 1, 0, 0, 0);
    idle(1, W2, 0, 0);
    // timeout after 8 idle cycles
    add(1, 8'hAA, 0, W2, 0, 0, 1, 1);
    add(1, 8'hBB, 0, W2, 0, 0, 1, 2);
    idle(7, W2, 1, 2);
    add(0, 8'h00, 0, W2, 0, 1, 0, 0);
    idle(1, W2, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(1, 8'(i), 0, W2, 0, 0, 1, i);
    add(1, 8'h05, 0, W3, 1, 0, 0, 0);
    // byte on the 8th idle cycle beats the timeout
    add(1, 8'h01, 0, W3, 0, 0, 1, 1);
    idle(7, W3, 1, 1);
    add(1, 8'h02, 0, W3, 0, 0, 1, 2);
    idle(7, W3, 1, 2);
    add(0, 8'h00, 0, W3, 0, 1, 0, 0);
    idle(1, W3, 0, 0);
    // clear beats a simultaneous byte
    add(1, 8'h0A, 0, W3, 0, 0, 1, 1);
    add(1, 8'h0B, 0, W3, 0, 0, 1, 2);
    add(1, 8'h0C, 0, W3, 0, 0, 1, 3);
    add(1, 8'hFF, 1, W3, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      add(1, 8'(16 * i), 0, W3, 0, 0, 1, i);
    add(1, 8'h50, 0, W4, 1, 0, 0, 0);
    idle(1, W4, 0, 0);

    bus.byteIn = 8'h00;
    bus.byteValid = 1'b0;
    bus.clear = 1'b0;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].bv, vq[i].b, vq[i].clr);
      chk_all($sformatf("row%0d", i), vq[i].d, vq[i].dv,
              vq[i].te, vq[i].bz, vq[i].c);
    end

    // asynchronous reset mid-frame
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0);
    chk_all("pre_rst", W4, 0, 0, 1, 4);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 8'h01, 0);
    chk_all("restart", 0, 0, 0, 1, 1);
    for (int i = 2; i <= 4; i++) step(1, 8'(i), 0);
    step(1, 8'h05, 0);
    chk_all("post_rst", W3, 1, 0, 0, 0);
    step(0, 8'h00, 0);
    chk_all("post_idle", W3, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_receiver.md
Name: data_receiver

Overview:
- Receive-side counterpart of DataSender: assembles a stream of bytes from the UART receiver into one NUM_BYTES-wide word.
- The first byte received is the least-significant byte, matching DataSender's send order (a 40-bit word 'h1122334455 arrives as 55,44,33,22,11).
- Sits between the UART RX byte interface and the consumer logic.
- An inter-byte timeout resynchronises framing after dropped bytes.

Parameters:
- NUM_BYTES, 5, bytes per word; legal range >= 2.
- TIMEOUT_CYCLES, 1000, idle clocks after the last accepted byte before a partial frame is discarded; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- byteIn  input  8  received byte; sampled only when byteValid=1.
- byteValid  input  1  one-cycle strobe from the UART receiver: byteIn holds a new byte.
- clear  input  1  synchronous flush of any partial frame.
- dataOut  output  8*NUM_BYTES  last complete word; held until the next complete frame.
- dataValid  output  1  one-cycle pulse: dataOut was just updated.
- timeoutErr  output  1  one-cycle pulse: a partial frame was discarded by timeout.
- busy  output  1  1 while a partial frame is held (state RECEIVING).
- byteCount  output  clog2(NUM_BYTES+1)  number of bytes held in the current partial frame.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, dataOut=0, dataValid=0, timeoutErr=0, busy=0, byteCount=0, shadow register=0, timer=0.
- Internal registers: shadow[8*NUM_BYTES-1:0], byte index byteCount, timeout timer sized for TIMEOUT_CYCLES.
- dataValid and timeoutErr default to 0 every cycle; each is 1 only in the cycle after the edge that triggers it.
- State IDLE, byteValid=1:
  - shadow[7:0] <= byteIn, byteCount <= 1, timer <= 0, go to RECEIVING.
- State RECEIVING, byteValid=1:
  - shadow[8*byteCount +: 8] <= byteIn, timer <= 0.
  - If byteCount == NUM_BYTES-1: on the same edge, dataOut <= {byteIn, shadow lower bytes}, dataValid <= 1, byteCount <= 0, go to IDLE.
  - Otherwise: byteCount <= byteCount+1.
- Latency: dataOut changes on the edge that samples the final byteValid; dataValid is high for exactly the following cycle.
- Back-to-back frames: a byteValid in the cycle dataValid is high starts a new frame normally.
- State RECEIVING, byteValid=0:
  - Timer increments each cycle.
  - When timer reaches TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0: discard the partial frame, byteCount <= 0, timer <= 0, timeoutErr <= 1, go to IDLE.
  - dataOut is untouched.
- byteValid in the cycle the timeout would fire: the byte is accepted, the timer clears, and no timeout occurs.
- clear=1 (either state):
  - byteCount <= 0, timer <= 0, go to IDLE; no dataValid, no timeoutErr.
  - clear has priority over byteValid; a byte in the same cycle is dropped.
  - dataOut is retained.
- Bytes are never stored outside a frame. Unused shadow bytes are don't-care, because dataOut only updates on a complete frame.
- Reset mid-frame: the partial frame is lost, outputs return to reset values asynchronously, and reception restarts at byte 0 after rst=1.
- busy = (state == RECEIVING), driven combinationally from the state register.

Test Plan:
- Reset, then byteValid pulses with byteIn 55,44,33,22,11, each separated by 1 idle cycle -> byteCount steps 1,2,3,4 then 0. dataOut='h1122334455 on the 5th edge, dataValid high exactly 1 cycle, busy falls with it.
- Frame 'h1122334455, then pulses 12,34,12,34,12 -> dataOut stays 'h1122334455 until the 5th byte, then becomes 'h1234123412 with one dataValid pulse.
- TIMEOUT_CYCLES=8: send 2 bytes (AA,BB), then idle 8 cycles -> timeoutErr pulses once, byteCount=0, dataOut unchanged. Then bytes 01..05 -> dataOut='h0504030201.
- TIMEOUT_CYCLES=8: byteValid arrives exactly on the 8th idle cycle -> no timeoutErr, byteCount increments, timer restarts.
- After 3 bytes, assert clear together with byteValid (byteIn=FF) -> byte dropped, byteCount=0, busy=0, no pulses. The next 5 bytes 10..50 give dataOut='h5040302010.
- Drive rst=0 asynchronously (between edges) after 4 bytes -> outputs go to 0 immediately. After release, 5 bytes 01..05 give dataOut='h0504030201 with no stale data.
